// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end that shares one pipelined adder
// between several requesters. Each accepted operation carries its requester
// tag through the adder's metadata path so results can be routed back.
// Multi-beat sequences (req_last=0) lock the grant to one owner so carries
// can be chained across beats. Each requester is limited in how many
// operations it may have in flight.
module adder_arbiter #(
  parameter int num_requesters  = 4,
  parameter int width           = 32,
  parameter int max_outstanding = 4,
  parameter int id_width        = (num_requesters > 1) ? $clog2(num_requesters) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [num_requesters-1:0]        req_valid,
  output logic [num_requesters-1:0]        req_ready,
  input  logic [num_requesters*width-1:0]  req_lhs,
  input  logic [num_requesters*width-1:0]  req_rhs,
  input  logic [num_requesters-1:0]        req_icarry,
  input  logic [num_requesters-1:0]        req_last,
  output logic [num_requesters-1:0]        rsp_valid,
  input  logic [num_requesters-1:0]        rsp_ready,
  output logic [width-1:0]                 rsp_res,
  output logic                             rsp_ocarry,
  output logic                             add_ivalid,
  input  logic                             add_iready,
  output logic [id_width-1:0]              add_imeta,
  output logic [width-1:0]                 add_lhs,
  output logic [width-1:0]                 add_rhs,
  output logic                             add_icarry,
  input  logic                             add_ovalid,
  output logic                             add_oready,
  input  logic [id_width-1:0]              add_ometa,
  input  logic [width-1:0]                 add_res,
  input  logic                             add_ocarry,
  output logic                             idle
);

  localparam int CNT_W = $clog2(max_outstanding + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [id_width-1:0]  r_rr_ptr;
  logic [id_width-1:0]  w_rr_ptr_nxt;
  logic [id_width-1:0]  r_owner;
  logic [id_width-1:0]  w_owner_nxt;
  logic [CNT_W-1:0]     r_count [num_requesters];

  logic [num_requesters-1:0] w_elig;
  logic [num_requesters-1:0] w_inc;
  logic [num_requesters-1:0] w_dec;
  logic                      w_found;
  logic [id_width-1:0]       w_winner;
  logic [id_width-1:0]       w_idx;
  logic [id_width-1:0]       w_ptr_inc;
  logic                      w_last_sel;
  logic                      w_accept;
  logic                      w_meta_ok;
  logic                      w_rsp_rdy;
  logic                      w_all_zero;

  // A requester may compete only while it has credit left
  always_comb begin
    w_elig = '0;
    for (int k = 0; k < num_requesters; k++) begin
      w_elig[k] = req_valid[k] && (r_count[k] < CNT_W'(max_outstanding));
    end
  end

  // Pick the winner: the lock owner only, or the first eligible from rr_ptr
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    if (r_state == S_LOCKED) begin
      if (w_elig[r_owner]) begin
        w_found  = 1'b1;
        w_winner = r_owner;
      end
    end else begin
      for (int i = 0; i < num_requesters; i++) begin
        w_idx = id_width'((int'(r_rr_ptr) + i) % num_requesters);
        if (!w_found && w_elig[w_idx]) begin
          w_found  = 1'b1;
          w_winner = w_idx;
        end
      end
    end
  end

  // Steer the winner's operands onto the adder input and hand back its ready
  always_comb begin
    add_lhs    = '0;
    add_rhs    = '0;
    add_icarry = 1'b0;
    w_last_sel = 1'b0;
    req_ready  = '0;
    for (int k = 0; k < num_requesters; k++) begin
      if (w_winner == id_width'(k)) begin
        add_lhs      = req_lhs[k*width +: width];
        add_rhs      = req_rhs[k*width +: width];
        add_icarry   = req_icarry[k];
        w_last_sel   = req_last[k];
        req_ready[k] = reset && w_found && add_iready;
      end
    end
    add_ivalid = reset && w_found;
    add_imeta  = w_winner;
  end

  assign w_accept  = add_ivalid && add_iready;
  assign w_ptr_inc = (w_winner == id_width'(num_requesters - 1)) ? '0 : w_winner + 1'b1;

  // Route the adder output to the tagged requester; unknown tags are drained
  always_comb begin
    rsp_valid = '0;
    w_meta_ok = 1'b0;
    w_rsp_rdy = 1'b0;
    for (int k = 0; k < num_requesters; k++) begin
      if (add_ometa == id_width'(k)) begin
        w_meta_ok    = 1'b1;
        w_rsp_rdy    = rsp_ready[k];
        rsp_valid[k] = reset && add_ovalid;
      end
    end
    add_oready = reset && (w_meta_ok ? w_rsp_rdy : 1'b1);
  end

  assign rsp_res    = add_res;
  assign rsp_ocarry = add_ocarry;

  // Credit bookkeeping events: issue increments, delivery decrements
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int k = 0; k < num_requesters; k++) begin
      w_inc[k] = w_accept && (w_winner == id_width'(k));
      w_dec[k] = add_ovalid && add_oready && (add_ometa == id_width'(k));
    end
  end

  // Per-requester in-flight counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < num_requesters; k++) r_count[k] <= '0;
    end else begin
      for (int k = 0; k < num_requesters; k++) begin
        case ({w_inc[k], w_dec[k]})
          2'b10:   r_count[k] <= r_count[k] + 1'b1;
          2'b01:   r_count[k] <= r_count[k] - 1'b1;
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end

  // Lock/pointer next state: final beat releases and advances, others lock
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_accept) begin
      if (w_last_sel) begin
        w_state_nxt  = S_IDLE;
        w_rr_ptr_nxt = w_ptr_inc;
      end else begin
        w_state_nxt = S_LOCKED;
        w_owner_nxt = w_winner;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Idle when unlocked and nothing is in flight for anyone
  always_comb begin
    w_all_zero = 1'b1;
    for (int k = 0; k < num_requesters; k++) begin
      if (r_count[k] != '0) w_all_zero = 1'b0;
    end
    idle = !reset || ((r_state == S_IDLE) && w_all_zero);
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vectors per requester, a behavioural
// adder with fixed latency and a bounded queue, and a scoreboard checked by
// an independent response monitor.
module tb_adder_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IW  = 2;
  localparam int ADQ = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid, req_ready, req_icarry, req_last;
  logic [N*W-1:0] req_lhs, req_rhs;
  logic [N-1:0]   rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_res;
  logic           rsp_ocarry;
  logic           add_ivalid, add_iready, add_icarry, add_ovalid, add_oready, add_ocarry;
  logic [IW-1:0]  add_imeta, add_ometa;
  logic [W-1:0]   add_lhs, add_rhs, add_res;
  logic           idle;

  always #5 clk = ~clk;

  adder_arbiter #(.num_requesters(N), .width(W), .max_outstanding(4)) dut (
    .clock(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_lhs(req_lhs), .req_rhs(req_rhs),
    .req_icarry(req_icarry), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_ocarry(rsp_ocarry),
    .add_ivalid(add_ivalid), .add_iready(add_iready), .add_imeta(add_imeta),
    .add_lhs(add_lhs), .add_rhs(add_rhs), .add_icarry(add_icarry),
    .add_ovalid(add_ovalid), .add_oready(add_oready), .add_ometa(add_ometa),
    .add_res(add_res), .add_ocarry(add_ocarry), .idle(idle)
  );

  typedef struct { int id; logic [31:0] lhs; logic [31:0] rhs; logic ic; logic last;
                   logic [31:0] eres; logic ecar; } vec_t;
  typedef struct { int id; logic [31:0] res; logic car; } exp_t;
  typedef struct { logic [1:0] meta; logic [31:0] res; logic car; int rdy; } aop_t;
  typedef struct { int id; int meta; int cyc; } acc_t;

  vec_t pend[$];
  exp_t sb[$];
  aop_t aq[$];
  acc_t acc_log[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic          iready_en = 1'b1;
  logic [N-1:0]  acc_k = '0;
  logic          add_acc = 1'b0, add_dlv = 1'b0;
  logic [IW-1:0] cap_meta;
  logic [31:0]   cap_lhs, cap_rhs;
  logic          cap_ic;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int head_of(input int k);
    for (int i = 0; i < pend.size(); i++) if (pend[i].id == k) return i;
    return -1;
  endfunction

  task automatic add_vec(input int id, input logic [31:0] l, input logic [31:0] r, input logic ic,
                         input logic last, input logic [31:0] eres, input logic ecar);
    vec_t v;
    v.id = id; v.lhs = l; v.rhs = r; v.ic = ic; v.last = last; v.eres = eres; v.ecar = ecar;
    pend.push_back(v);
  endtask

  // Stimulus engine and behavioural adder, updated just after each clock edge
  initial begin : engine
    int idx;
    aop_t a;
    logic [32:0] s;
    req_valid = '0; req_lhs = '0; req_rhs = '0; req_icarry = '0; req_last = '0;
    add_iready = 1'b0; add_ovalid = 1'b0; add_ometa = '0; add_res = '0; add_ocarry = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (acc_k[k]) begin
          idx = head_of(k);
          if (idx >= 0) pend.delete(idx);
        end
      end
      if (add_dlv && aq.size() > 0) void'(aq.pop_front());
      if (add_acc) begin
        s = {1'b0, cap_lhs} + {1'b0, cap_rhs} + {32'd0, cap_ic};
        a.meta = cap_meta; a.res = s[31:0]; a.car = s[32]; a.rdy = cyc + 1;
        aq.push_back(a);
      end
      for (int k = 0; k < N; k++) begin
        idx = head_of(k);
        if (idx >= 0) begin
          req_valid[k] = 1'b1;
          req_lhs[k*W +: W] = pend[idx].lhs;
          req_rhs[k*W +: W] = pend[idx].rhs;
          req_icarry[k] = pend[idx].ic;
          req_last[k] = pend[idx].last;
        end else begin
          req_valid[k] = 1'b0;
        end
      end
      add_ovalid = (aq.size() > 0) && (aq[0].rdy <= cyc);
      if (aq.size() > 0) begin
        add_ometa = aq[0].meta; add_res = aq[0].res; add_ocarry = aq[0].car;
      end
      add_iready = iready_en && (aq.size() < ADQ);
    end
  end

  // Issue side: record handshakes and push the expected response of each accepted vector
  initial begin : issue
    int idx;
    exp_t e;
    acc_t l;
    forever begin
      @(negedge clk);
      acc_k    = req_valid & req_ready;
      add_acc  = add_ivalid && add_iready;
      add_dlv  = add_ovalid && add_oready;
      cap_meta = add_imeta; cap_lhs = add_lhs; cap_rhs = add_rhs; cap_ic = add_icarry;
      for (int k = 0; k < N; k++) begin
        if (acc_k[k]) begin
          idx = head_of(k);
          if (idx >= 0) begin
            e.id = k; e.res = pend[idx].eres; e.car = pend[idx].ecar;
            sb.push_back(e);
            l.id = k; l.meta = int'(add_imeta); l.cyc = cyc;
            acc_log.push_back(l);
          end
        end
      end
    end
  end

  // Response monitor: every delivered result is compared against the scoreboard head
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ((rsp_valid & rsp_ready) != '0)) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 64'(rsp_valid), 64'(1) << e.id);
          chk("rsp_res", 64'(rsp_res), 64'(e.res));
          chk("rsp_carry", 64'(rsp_ocarry), 64'(e.car));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_add_ivalid"}, 64'(add_ivalid), 64'd0);
    chk({tag, "_add_oready"}, 64'(add_oready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(tag);
    pend.delete(); sb.delete(); aq.delete(); acc_log.delete();
    iready_en = 1'b1; rsp_ready = '1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    int t = 0;
    while (acc_log.size() < n && t < budget) begin @(posedge clk); t++; end
    chk({tag, "_accepts"}, 64'(acc_log.size() >= n), 64'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int t = 0;
    while ((sb.size() != 0 || pend.size() != 0) && t < budget) begin @(posedge clk); t++; end
    chk({tag, "_drain"}, 64'(sb.size() + pend.size()), 64'd0);
  endtask

  task automatic chk_grant(input string tag, input int i, input int exp_id);
    if (acc_log.size() <= i) begin
      chk({tag, "_grant_missing"}, 64'(acc_log.size()), 64'(i + 1));
    end else begin
      chk({tag, "_grant_id"}, 64'(acc_log[i].id), 64'(exp_id));
      chk({tag, "_grant_meta"}, 64'(acc_log[i].meta), 64'(exp_id));
    end
  endtask

  task automatic chk_back_to_back(input string tag, input int first, input int last);
    for (int i = first + 1; i <= last; i++) begin
      if (acc_log.size() > i) chk({tag, "_consecutive"}, 64'(acc_log[i].cyc - acc_log[i-1].cyc), 64'd1);
    end
  endtask

  initial begin : main
    int fair_exp[8];
    int lock_exp[5];
    fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    lock_exp = '{1, 1, 1, 3, 0};
    rsp_ready = '1;
    #1;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single operation from requester 2
    do_reset("t1_rst");
    add_vec(2, 32'h5, 32'h7, 1'b0, 1'b1, 32'hC, 1'b0);
    wait_acc("t1", 1, 20);
    chk_grant("t1", 0, 2);
    #2 chk("t1_busy", 64'(idle), 64'd0);
    wait_drain("t1", 20);
    @(negedge clk);
    chk("t1_idle", 64'(idle), 64'd1);

    // Round-robin fairness across all four requesters
    do_reset("t2_rst");
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++)
        add_vec(k, 32'(k + 1), 32'(r * 16), 1'b0, 1'b1, 32'(k + 1 + r * 16), 1'b0);
    wait_acc("t2", 8, 40);
    for (int i = 0; i < 8; i++) chk_grant("t2", i, fair_exp[i]);
    chk_back_to_back("t2", 0, 7);
    wait_drain("t2", 40);

    // Locked 96-bit chained add from requester 1 while 0 and 3 wait
    do_reset("t3_rst");
    add_vec(0, 32'h1, 32'h1, 1'b0, 1'b1, 32'h2, 1'b0);
    wait_acc("t3_pre", 1, 20);
    wait_drain("t3_pre", 20);
    acc_log.delete();
    add_vec(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1);
    add_vec(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    add_vec(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    add_vec(0, 32'h3, 32'h4, 1'b0, 1'b1, 32'h7, 1'b0);
    add_vec(3, 32'd10, 32'd20, 1'b0, 1'b1, 32'd30, 1'b0);
    wait_acc("t3", 5, 40);
    for (int i = 0; i < 5; i++) chk_grant("t3", i, lock_exp[i]);
    chk_back_to_back("t3", 0, 3);
    wait_drain("t3", 40);

    // Credit limit on requester 0 with its responses held off
    do_reset("t4_rst");
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) add_vec(0, 32'(i), 32'd100, 1'b1, 1'b1, 32'(101 + i), 1'b0);
    repeat (10) @(posedge clk);
    chk("t4_four_accepts", 64'(acc_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk_grant("t4", i, 0);
    @(negedge clk);
    chk("t4_req0_valid", 64'(req_valid[0]), 64'd1);
    chk("t4_req0_stalled", 64'(req_ready[0]), 64'd0);
    chk("t4_no_issue", 64'(add_ivalid), 64'd0);
    add_vec(1, 32'h20, 32'h22, 1'b0, 1'b1, 32'h42, 1'b0);
    wait_acc("t4_r1", 5, 20);
    chk_grant("t4_r1", 4, 1);
    rsp_ready[0] = 1'b1;
    wait_acc("t4_r0", 6, 40);
    chk_grant("t4_r0", 5, 0);
    wait_drain("t4", 60);

    // Adder backpressure holds the grant stable
    do_reset("t5_rst");
    iready_en = 1'b0;
    add_vec(2, 32'h1234, 32'h1111, 1'b1, 1'b1, 32'h2346, 1'b0);
    @(posedge clk); #2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_ready", 64'(req_ready), 64'd0);
      chk("t5_ivalid", 64'(add_ivalid), 64'd1);
      chk("t5_meta", 64'(add_imeta), 64'd2);
      chk("t5_lhs", 64'(add_lhs), 64'h1234);
    end
    chk("t5_none_accepted", 64'(acc_log.size()), 64'd0);
    chk("t5_idle", 64'(idle), 64'd1);
    iready_en = 1'b1;
    @(negedge clk); #1;
    chk("t5_first_ready_accept", 64'(acc_log.size()), 64'd1);
    wait_drain("t5", 20);

    // Reset while locked with two beats in flight
    do_reset("t6_pre");
    rsp_ready = '0;
    add_vec(2, 32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0);
    add_vec(2, 32'h2, 32'h2, 1'b0, 1'b0, 32'h4, 1'b0);
    add_vec(2, 32'h3, 32'h3, 1'b0, 1'b1, 32'h6, 1'b0);
    wait_acc("t6_lock", 2, 20);
    iready_en = 1'b0;
    #2 chk("t6_busy", 64'(idle), 64'd0);
    do_reset("t6_midlock");
    add_vec(3, 32'h5, 32'h6, 1'b0, 1'b1, 32'hB, 1'b0);
    add_vec(0, 32'h9, 32'h9, 1'b0, 1'b1, 32'h12, 1'b0);
    wait_acc("t6_after", 2, 20);
    chk_grant("t6_after", 0, 0);
    chk_grant("t6_after", 1, 3);
    wait_drain("t6", 20);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
